// File: rtl/data_selector_pkg.sv
// Shared sizing helpers for the pipelined nibble selector: width math, identity
// table generation and flattened-lane offsets.
package data_selector_pkg;

  localparam int MAX_TABLE_BITS = 1024;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  function automatic int totalSources(input int mainInputs, input int regsInputs);
    return mainInputs + regsInputs;
  endfunction

  // One extra code point so every index >= totalSources is representable as "none".
  function automatic int selWidth(input int total);
    return clog2(total + 1);
  endfunction

  function automatic logic [MAX_TABLE_BITS-1:0] identityTable(input int numLanes, input int selW);
    logic [MAX_TABLE_BITS-1:0] t;
    t = '0;
    for (int k = 0; k < numLanes; k++) begin
      for (int b = 0; b < selW; b++) begin
        if (k * selW + b < MAX_TABLE_BITS) t[k*selW+b] = k[b];
      end
    end
    return t;
  endfunction

  function automatic int laneLsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/data_selector_pipe_if.sv
// Handshake, data and config bundle for data_selector_pipe.
// out_parity exists only when DATA_SELECTOR_PARITY_EN is defined.
interface data_selector_pipe_if
  import data_selector_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int NUM_LANES   = 4
) ();

  localparam int SEL_WIDTH  = selWidth(totalSources(MAIN_INPUTS, REGS_INPUTS));
  localparam int LANE_IDX_W = clog2(NUM_LANES);

  logic                                in_valid;
  logic                                in_ready;
  logic [MAIN_INPUTS*DATA_WIDTH-1:0]   wData;
  logic [REGS_INPUTS*DATA_WIDTH-1:0]   wRegs;
  logic                                cfg_we;
  logic [LANE_IDX_W-1:0]               cfg_lane;
  logic [SEL_WIDTH-1:0]                cfg_sel;
  logic                                cfg_commit;
  logic                                out_valid;
  logic                                out_ready;
  logic [NUM_LANES*DATA_WIDTH-1:0]     data_out;
  logic                                sel_err;
`ifdef DATA_SELECTOR_PARITY_EN
  logic [NUM_LANES-1:0]                out_parity;
`endif

  modport master (
    output in_valid, wData, wRegs, cfg_we, cfg_lane, cfg_sel, cfg_commit, out_ready,
    input  in_ready, out_valid, data_out, sel_err
`ifdef DATA_SELECTOR_PARITY_EN
    , input out_parity
`endif
  );

  modport slave (
    input  in_valid, wData, wRegs, cfg_we, cfg_lane, cfg_sel, cfg_commit, out_ready,
    output in_ready, out_valid, data_out, sel_err
`ifdef DATA_SELECTOR_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/data_selector_lane_mux.sv
// Single output lane: picks one nibble from the main bus or register file,
// driving zero for any index past the last source.
module data_selector_lane_mux
  import data_selector_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int SEL_WIDTH   = 7
) (
  input  logic [SEL_WIDTH-1:0]              sel,
  input  logic [MAIN_INPUTS*DATA_WIDTH-1:0] wData,
  input  logic [REGS_INPUTS*DATA_WIDTH-1:0] wRegs,
  output logic [DATA_WIDTH-1:0]             lane
);

  // Equality decode keeps out-of-range indices at the zero default for free.
  always_comb begin
    lane = '0;
    for (int i = 0; i < MAIN_INPUTS; i++) begin
      if (sel == SEL_WIDTH'(i)) lane = wData[laneLsb(i, DATA_WIDTH) +: DATA_WIDTH];
    end
    for (int j = 0; j < REGS_INPUTS; j++) begin
      if (sel == SEL_WIDTH'(MAIN_INPUTS + j)) lane = wRegs[laneLsb(j, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/data_selector_pipe.sv
// Pipelined lane selector with double-buffered select table and registered
// valid/ready output. Optional per-lane parity under DATA_SELECTOR_PARITY_EN.
module data_selector_pipe
  import data_selector_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int MAIN_INPUTS = 16,
  parameter int REGS_INPUTS = 64,
  parameter int NUM_LANES   = 4
) (
  input logic                 clk,
  input logic                 rst,
  data_selector_pipe_if.slave bus
);

  localparam int TOTAL_SOURCES = totalSources(MAIN_INPUTS, REGS_INPUTS);
  localparam int SEL_WIDTH     = selWidth(TOTAL_SOURCES);
  localparam int LANE_IDX_W    = clog2(NUM_LANES);
  localparam int TABLE_W       = NUM_LANES * SEL_WIDTH;
  localparam int OUT_W         = NUM_LANES * DATA_WIDTH;

  localparam logic [MAX_TABLE_BITS-1:0] ID_FULL   = identityTable(NUM_LANES, SEL_WIDTH);
  localparam logic [TABLE_W-1:0]        ID_TABLE  = ID_FULL[TABLE_W-1:0];
  localparam logic [SEL_WIDTH-1:0]      SEL_LIMIT = SEL_WIDTH'(TOTAL_SOURCES);

  logic [TABLE_W-1:0] shadowTbl;
  logic [TABLE_W-1:0] activeTbl;
  logic [TABLE_W-1:0] shadowNext;
  logic [OUT_W-1:0]   muxOut;
  logic [OUT_W-1:0]   dataOut;
  logic               outValid;
  logic               selErr;
  logic               inReady;
  logic               accept;
  logic               laneHit;
  logic               cfgErr;

  assign inReady = !outValid || bus.out_ready;
  assign accept  = bus.in_valid && inReady;

  // shadowNext folds this cycle's write in so a same-cycle commit copies it.
  always_comb begin
    shadowNext = shadowTbl;
    laneHit    = 1'b0;
    for (int k = 0; k < NUM_LANES; k++) begin
      if (bus.cfg_lane == LANE_IDX_W'(k)) begin
        laneHit = 1'b1;
        if (bus.cfg_we) shadowNext[k*SEL_WIDTH +: SEL_WIDTH] = bus.cfg_sel;
      end
    end
    cfgErr = bus.cfg_we && (!laneHit || bus.cfg_sel >= SEL_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadowTbl <= ID_TABLE;
      activeTbl <= ID_TABLE;
      selErr    <= 1'b0;
    end else begin
      shadowTbl <= shadowNext;
      if (bus.cfg_commit) activeTbl <= shadowNext;
      if (cfgErr) selErr <= 1'b1;
    end
  end

  // The mux reads activeTbl before any commit at this edge lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      dataOut  <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      dataOut  <= muxOut;
    end else if (bus.out_ready) begin
      outValid <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    data_selector_lane_mux #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAIN_INPUTS(MAIN_INPUTS),
      .REGS_INPUTS(REGS_INPUTS),
      .SEL_WIDTH  (SEL_WIDTH)
    ) uLaneMux (
      .sel  (activeTbl[k*SEL_WIDTH +: SEL_WIDTH]),
      .wData(bus.wData),
      .wRegs(bus.wRegs),
      .lane (muxOut[laneLsb(k, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

`ifdef DATA_SELECTOR_PARITY_EN
  logic [NUM_LANES-1:0] parityNext;
  logic [NUM_LANES-1:0] outParity;

  always_comb begin
    parityNext = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      parityNext[k] = ^muxOut[laneLsb(k, DATA_WIDTH) +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) outParity <= '0;
    else if (accept) outParity <= parityNext;
  end

  assign bus.out_parity = outParity;
`endif

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.data_out  = dataOut;
  assign bus.sel_err   = selErr;

endmodule

// File: tb/tb_data_selector_pipe.sv
// Self-checking bench for data_selector_pipe: directed vector table, hand-built
// stall/reset sequences and randomized traffic against a behavioural model.
module tb_data_selector_pipe;
  import data_selector_pkg::*;

  localparam int DW = 4;
  localparam int MI = 16;
  localparam int RI = 64;
  localparam int NL = 4;

  localparam logic [63:0]  D0 = 64'h0123456789abcdef;
  localparam logic [63:0]  DF = 64'hffff_ffff_ffff_ffff;
  localparam logic [255:0] R5 = 256'h5;

  typedef struct {
    logic         rst;
    logic         inValid;
    logic         outReady;
    logic [63:0]  wData;
    logic [255:0] wRegs;
    logic         cfgWe;
    logic [1:0]   cfgLane;
    logic [6:0]   cfgSel;
    logic         cfgCommit;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        expValid;
    logic [15:0] expData;
    logic        expErr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_selector_pipe_if #(.DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI), .NUM_LANES(NL)) bus ();

  data_selector_pipe #(.DATA_WIDTH(DW), .MAIN_INPUTS(MI), .REGS_INPUTS(RI), .NUM_LANES(NL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Model state: select tables as plain source numbers, output as lane nibbles.
  int         mShadow[NL];
  int         mActive[NL];
  logic [3:0] mOut[NL];
  bit         mValid;
  bit         mErr;

  function automatic logic [3:0] modelSource(input logic [63:0] wd, input logic [255:0] wr, input int s);
    if (s < MI) return wd[s*4 +: 4];
    if (s < MI + RI) return wr[(s-MI)*4 +: 4];
    return 4'h0;
  endfunction

  function automatic logic [15:0] modelData();
    return {mOut[3], mOut[2], mOut[1], mOut[0]};
  endfunction

  function automatic logic [3:0] parityOf(input logic [15:0] d);
    logic [3:0] p;
    for (int k = 0; k < NL; k++) p[k] = ^d[k*4 +: 4];
    return p;
  endfunction

  function automatic stim_t mkStim(input logic inV, input logic oR, input logic [63:0] wd,
                                   input logic we, input logic [1:0] lane, input logic [6:0] sel,
                                   input logic commit);
    stim_t s;
    s.rst = 1'b0; s.inValid = inV; s.outReady = oR; s.wData = wd; s.wRegs = R5;
    s.cfgWe = we; s.cfgLane = lane; s.cfgSel = sel; s.cfgCommit = commit;
    return s;
  endfunction

  task automatic modelStep(input stim_t s);
    bit acc;
    acc = s.inValid && (!mValid || s.outReady);
    if (s.rst) begin
      mValid = 0;
      mErr   = 0;
      for (int k = 0; k < NL; k++) begin
        mOut[k] = 4'h0; mShadow[k] = k; mActive[k] = k;
      end
    end else begin
      if (acc) begin
        for (int k = 0; k < NL; k++) mOut[k] = modelSource(s.wData, s.wRegs, mActive[k]);
        mValid = 1;
      end else if (mValid && s.outReady) begin
        mValid = 0;
      end
      if (s.cfgWe) begin
        if (int'(s.cfgSel) >= MI + RI || int'(s.cfgLane) >= NL) mErr = 1;
        if (int'(s.cfgLane) < NL) mShadow[s.cfgLane] = int'(s.cfgSel);
      end
      if (s.cfgCommit) mActive = mShadow;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle, check in_ready before the edge and all outputs after it.
  task automatic applyStimulus(input string tag, input stim_t s);
    rst            = s.rst;
    bus.in_valid   = s.inValid;
    bus.out_ready  = s.outReady;
    bus.wData      = s.wData;
    bus.wRegs      = s.wRegs;
    bus.cfg_we     = s.cfgWe;
    bus.cfg_lane   = s.cfgLane;
    bus.cfg_sel    = s.cfgSel;
    bus.cfg_commit = s.cfgCommit;
    #1;
    if (!s.rst) checkOutput({tag, " in_ready"}, 64'(bus.in_ready), 64'(!mValid || s.outReady));
    @(posedge clk);
    modelStep(s);
    #1;
    checkOutput({tag, " data_out"}, 64'(bus.data_out), 64'(modelData()));
    checkOutput({tag, " out_valid"}, 64'(bus.out_valid), 64'(mValid));
    checkOutput({tag, " sel_err"}, 64'(bus.sel_err), 64'(mErr));
`ifdef DATA_SELECTOR_PARITY_EN
    checkOutput({tag, " out_parity"}, 64'(bus.out_parity), 64'(parityOf(modelData())));
`endif
  endtask

  vec_t  vecs[14];
  stim_t s;

  initial begin
    vecs[0]  = '{mkStim(1, 1, D0, 0, 0, 0,  0), 1'b1, 16'hcdef, 1'b0};
    vecs[1]  = '{mkStim(0, 0, D0, 1, 0, 16, 0), 1'b1, 16'hcdef, 1'b0};
    vecs[2]  = '{mkStim(0, 0, D0, 0, 0, 0,  1), 1'b1, 16'hcdef, 1'b0};
    vecs[3]  = '{mkStim(1, 1, D0, 0, 0, 0,  0), 1'b1, 16'hcde5, 1'b0};
    vecs[4]  = '{mkStim(1, 1, D0, 1, 0, 0,  1), 1'b1, 16'hcde5, 1'b0};
    vecs[5]  = '{mkStim(1, 1, D0, 0, 0, 0,  0), 1'b1, 16'hcdef, 1'b0};
    vecs[6]  = '{mkStim(1, 0, DF, 0, 0, 0,  0), 1'b1, 16'hcdef, 1'b0};
    vecs[7]  = '{mkStim(1, 0, DF, 0, 0, 0,  0), 1'b1, 16'hcdef, 1'b0};
    vecs[8]  = '{mkStim(1, 0, DF, 0, 0, 0,  0), 1'b1, 16'hcdef, 1'b0};
    vecs[9]  = '{mkStim(1, 1, DF, 0, 0, 0,  0), 1'b1, 16'hffff, 1'b0};
    vecs[10] = '{mkStim(0, 1, DF, 1, 2, 80, 1), 1'b0, 16'hffff, 1'b1};
    vecs[11] = '{mkStim(1, 1, DF, 0, 0, 0,  0), 1'b1, 16'hf0ff, 1'b1};
    vecs[12] = '{mkStim(1, 1, D0, 1, 2, 2,  1), 1'b1, 16'hc0ef, 1'b1};
    vecs[13] = '{mkStim(1, 1, D0, 0, 0, 0,  0), 1'b1, 16'hcdef, 1'b1};

    for (int k = 0; k < NL; k++) begin
      mShadow[k] = k; mActive[k] = k; mOut[k] = 4'h0;
    end
    mValid = 0;
    mErr   = 0;

    s = mkStim(0, 1, D0, 0, 0, 0, 0);
    s.rst = 1'b1;
    applyStimulus("reset0", s);
    applyStimulus("reset1", s);
    checkOutput("reset data_out", 64'(bus.data_out), 64'h0);
    checkOutput("reset out_valid", 64'(bus.out_valid), 64'h0);
    checkOutput("reset sel_err", 64'(bus.sel_err), 64'h0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].s);
      checkOutput($sformatf("vec%0d tbl data_out", i), 64'(bus.data_out), 64'(vecs[i].expData));
      checkOutput($sformatf("vec%0d tbl out_valid", i), 64'(bus.out_valid), 64'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d tbl sel_err", i), 64'(bus.sel_err), 64'(vecs[i].expErr));
`ifdef DATA_SELECTOR_PARITY_EN
      checkOutput($sformatf("vec%0d tbl out_parity", i), 64'(bus.out_parity), 64'(parityOf(vecs[i].expData)));
`endif
    end

    // Retarget lane0, fill the output, stall it, then reset mid-stall.
    applyStimulus("stall0", mkStim(0, 1, D0, 1, 0, 16, 1));
    applyStimulus("stall1", mkStim(1, 0, D0, 0, 0, 0, 0));
    checkOutput("stall1 fill", 64'(bus.data_out), 64'hcde5);
    applyStimulus("stall2", mkStim(1, 0, DF, 0, 0, 0, 0));
    checkOutput("stall2 hold", 64'(bus.data_out), 64'hcde5);
    s = mkStim(1, 0, DF, 0, 0, 0, 0);
    s.rst = 1'b1;
    applyStimulus("stallrst", s);
    checkOutput("stallrst data_out", 64'(bus.data_out), 64'h0);
    checkOutput("stallrst out_valid", 64'(bus.out_valid), 64'h0);
    checkOutput("stallrst sel_err", 64'(bus.sel_err), 64'h0);
    applyStimulus("postrst", mkStim(1, 1, D0, 0, 0, 0, 0));
    checkOutput("postrst identity", 64'(bus.data_out), 64'hcdef);

    for (int n = 0; n < 400; n++) begin
      s.rst       = ($urandom_range(0, 99) == 0);
      s.inValid   = ($urandom_range(0, 3) != 0);
      s.outReady  = ($urandom_range(0, 9) < 7);
      s.wData     = {$urandom, $urandom};
      for (int j = 0; j < 8; j++) s.wRegs[j*32 +: 32] = $urandom;
      s.cfgWe     = ($urandom_range(0, 3) == 0);
      s.cfgLane   = 2'($urandom_range(0, 3));
      s.cfgSel    = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(80, 127)) : 7'($urandom_range(0, 79));
      s.cfgCommit = ($urandom_range(0, 5) == 0);
      applyStimulus($sformatf("rand%0d", n), s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
